adc_conv_ctrl: RTL and testbench
================================

# adc_conv_ctrl

Conversion controller for the AD7864 4-channel 12-bit ADC, implemented in the CPLD. It receives a one-cycle start pulse from the sequence detector match output or from the DSP strobe. On each start it pulses CONVST, tracks BUSY, then reads NCH results over the parallel bus with CS/RD. Each result is presented to the DSP-side capture logic as a channel-tagged word with a one-cycle valid strobe.

## Interface
Parameters:
- NCH, 4 — channels read per conversion (1..4)
- CONVST_CYCLES, 2 — convst_n low width in clocks (≥1)
- RD_CYCLES, 3 — rd_n low width per read in clocks (≥2)
- BUSY_TIMEOUT, 64 — max clocks spent waiting on either BUSY edge

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle conversion request
- busy  in  1  AD7864 BUSY, asynchronous, active-high
- db  in  12  AD7864 data bus
- convst_n  out  1  conversion start, active-low
- cs_n  out  1  chip select, active-low
- rd_n  out  1  read strobe, active-low
- data_out  out  12  last captured sample
- ch_out  out  2  channel index of data_out (0..NCH-1)
- data_valid  out  1  one-cycle strobe, data_out/ch_out new
- done  out  1  one-cycle strobe, frame complete
- ready  out  1  high in IDLE only
- err  out  1  sticky BUSY timeout flag

## Operation
- busy passes through a 2-flop synchronizer (busy_s); the FSM uses only busy_s.
- States: IDLE, CONV, WAIT_BH, WAIT_BL, READ, GAP, FIN.
- IDLE: when start=1, clear err and the channel counter, then go to CONV. When start=0, stay in IDLE.
- CONV: convst_n=0 for exactly CONVST_CYCLES clocks, then go to WAIT_BH.
- WAIT_BH: wait for busy_s=1, then go to WAIT_BL. Timeout → IDLE with err=1.
- WAIT_BL: wait for busy_s=0, then go to READ. Timeout → IDLE with err=1.
- READ: cs_n=0 and rd_n=0 for RD_CYCLES clocks. On the final clock edge: db→data_out, counter→ch_out, data_valid=1 for one cycle.
- After READ: if the counter equals NCH-1, go to FIN. Otherwise increment the counter and go to GAP.
- GAP: cs_n=0, rd_n=1 for one clock, then go to READ.
- FIN: cs_n=1, done=1 for one cycle, then go to IDLE.
- Timeout counter: resets on entry to WAIT_BH and WAIT_BL and increments each clock in those states. A timeout fires when the counter reaches BUSY_TIMEOUT-1 without the awaited level. Reads do not occur after a timeout.
- start outside IDLE is ignored and is not queued.
- data_out and ch_out hold their values until the next capture. err holds until the next accepted start.

## Timing
- Reset values (asserted asynchronously):
  - convst_n=1, cs_n=1, rd_n=1
  - data_out=0, ch_out=0
  - data_valid=0, done=0, err=0
  - ready=1, state=IDLE
  - synchronizer flops=0
- Reset mid-frame aborts immediately. No done or data_valid is produced for the aborted frame.
- start sampled high at edge E: convst_n falls after E and rises after edge E+CONVST_CYCLES. ready falls after E.
- Sync latency: a busy change is visible to the FSM 2 edges later.
- Read n (0-based) starts at clock R0 + n·(RD_CYCLES+1), where R0 is the first READ cycle.
- data_valid and rd_n rising occur together after the last rd_n-low cycle; db is sampled at that edge.
- done is asserted in the cycle after the last data_valid. ready rises one cycle after done.
- Minimum frame length: 1 + CONVST_CYCLES + 2 + 2 + NCH·RD_CYCLES + (NCH-1) + 1 clocks, excluding ADC conversion time.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Nominal frame, defaults: start pulse; model raises busy 3 clocks after convst_n rises and holds it 10 clocks; db=0x100+ch per read → four data_valid pulses with (ch_out, data_out) = (0,0x100), (1,0x101), (2,0x102), (3,0x103). Each rd_n low exactly 3 clocks, with a 1-clock gap between reads. One done pulse; err=0.
- Busy never asserts: start, busy held 0 → exactly 64 clocks in WAIT_BH, then err=1, ready=1, cs_n/rd_n never low, no done.
- Busy stuck high: busy rises and never falls → timeout in WAIT_BL, err=1. A following good frame clears err at its start and completes normally.
- start during frame: second start pulse during READ → ignored; exactly 4 data_valid and 1 done.
- Reset mid-read: assert reset while rd_n=0 on channel 2 → all outputs return to reset values immediately. A subsequent start gives a clean 4-channel frame beginning at ch_out=0.
- NCH=1, RD_CYCLES=2 build: one read with 2-clock rd_n low, no GAP, done the cycle after data_valid, ch_out=0.

Source files
------------

// File: rtl/adc_conv_ctrl.sv
// Conversion controller for the AD7864: pulses CONVST, tracks BUSY through a
// synchronizer, then reads NCH channel results over the CS/RD parallel bus.
module adc_conv_ctrl #(
    parameter int NCH           = 4,
    parameter int CONVST_CYCLES = 2,
    parameter int RD_CYCLES     = 3,
    parameter int BUSY_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        busy,
    input  logic [11:0] db,
    output logic        convst_n,
    output logic        cs_n,
    output logic        rd_n,
    output logic [11:0] data_out,
    output logic [1:0]  ch_out,
    output logic        data_valid,
    output logic        done,
    output logic        ready,
    output logic        err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CONV    = 3'd1;
    localparam logic [2:0] WAIT_BH = 3'd2;
    localparam logic [2:0] WAIT_BL = 3'd3;
    localparam logic [2:0] READ    = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;
    localparam logic [2:0] FIN     = 3'd6;

    localparam int PW = $clog2((CONVST_CYCLES > RD_CYCLES ? CONVST_CYCLES : RD_CYCLES) + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [PW-1:0] CONV_LAST = PW'(CONVST_CYCLES - 1);
    localparam logic [PW-1:0] RD_LAST   = PW'(RD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(BUSY_TIMEOUT - 1);
    localparam logic [1:0]    CH_LAST   = 2'(NCH - 1);

    logic [2:0]    state;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [1:0]    ch;
    logic          busy_meta;
    logic          busy_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= busy;
            busy_s    <= busy_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pcnt       <= '0;
            tcnt       <= '0;
            ch         <= '0;
            convst_n   <= 1'b1;
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            data_out   <= '0;
            ch_out     <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b1;
            err        <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            data_valid <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        ch       <= '0;
                        pcnt     <= '0;
                        convst_n <= 1'b0;
                        state    <= CONV;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                CONV: begin
                    if (pcnt == CONV_LAST) begin
                        convst_n <= 1'b1;
                        tcnt     <= '0;
                        state    <= WAIT_BH;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                WAIT_BH: begin
                    if (busy_s) begin
                        tcnt  <= '0;
                        state <= WAIT_BL;
                    end else if (tcnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WAIT_BL: begin
                    if (!busy_s) begin
                        cs_n  <= 1'b0;
                        rd_n  <= 1'b0;
                        pcnt  <= '0;
                        state <= READ;
                    end else if (tcnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                READ: begin
                    if (pcnt == RD_LAST) begin
                        rd_n       <= 1'b1;
                        data_out   <= db;
                        ch_out     <= ch;
                        data_valid <= 1'b1;
                        if (ch == CH_LAST) begin
                            cs_n  <= 1'b1;
                            state <= FIN;
                        end else begin
                            ch    <= ch + 2'd1;
                            state <= GAP;
                        end
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                GAP: begin
                    rd_n  <= 1'b0;
                    pcnt  <= '0;
                    state <= READ;
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Scoreboard bench for adc_conv_ctrl: a default build and an NCH=1/RD_CYCLES=2
// build, each driven by a small AD7864 model.
module tb_adc_conv_ctrl;

    typedef struct packed {
        logic [1:0]  ch;
        logic [11:0] data;
    } sample_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, busy, start1, busy1;
    logic [11:0] db, db1;
    logic        convst_n, cs_n, rd_n, data_valid, done, ready, err;
    logic [11:0] data_out;
    logic [1:0]  ch_out;
    logic        convst_n1, cs_n1, rd_n1, data_valid1, done1, ready1, err1;
    logic [11:0] data_out1;
    logic [1:0]  ch_out1;

    always #5 clk = ~clk;

    adc_conv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .db(db),
        .convst_n(convst_n), .cs_n(cs_n), .rd_n(rd_n), .data_out(data_out),
        .ch_out(ch_out), .data_valid(data_valid), .done(done), .ready(ready), .err(err)
    );

    adc_conv_ctrl #(.NCH(1), .RD_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .db(db1),
        .convst_n(convst_n1), .cs_n(cs_n1), .rd_n(rd_n1), .data_out(data_out1),
        .ch_out(ch_out1), .data_valid(data_valid1), .done(done1), .ready(ready1), .err(err1)
    );

    int      n_vec = 0;
    int      n_bad = 0;
    sample_t exp_q[$];
    sample_t exp_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC data model: result index advances on each rd_n rising edge, restarts on CONVST.
    int   rd_idx = 0, rd_idx1 = 0;
    logic rd_q = 1'b1, rd_q1 = 1'b1;
    always @(negedge clk) begin
        if (!convst_n) rd_idx <= 0;
        else if (rd_n && !rd_q) rd_idx <= rd_idx + 1;
        if (!convst_n1) rd_idx1 <= 0;
        else if (rd_n1 && !rd_q1) rd_idx1 <= rd_idx1 + 1;
        rd_q  <= rd_n;
        rd_q1 <= rd_n1;
    end
    assign db  = 12'h100 + 12'(rd_idx);
    assign db1 = 12'h100 + 12'(rd_idx1);

    // Monitor for the default build.
    int   dv_cnt = 0, done_cnt = 0, conv_cnt = 0, cs_low_cnt = 0;
    int   rd_run = 0, cs_run = 0;
    logic p_rd = 1'b1, p_cs = 1'b1, p_dv = 1'b0, p_done = 1'b0, p_conv = 1'b1;
    initial begin : monitor0
        sample_t s;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_run = 0; cs_run = 0;
                p_rd = 1'b1; p_cs = 1'b1; p_dv = 1'b0; p_done = 1'b0; p_conv = 1'b1;
            end else begin
                if (data_valid) begin
                    dv_cnt++;
                    check("scoreboard holds entry at data_valid", 32'(exp_q.size() > 0), 32'(1));
                    if (exp_q.size() > 0) begin
                        s = exp_q.pop_front();
                        check("sample {ch,data}", 32'({ch_out, data_out}), 32'(s));
                    end
                    check("rd_n rises with data_valid", 32'({p_rd, rd_n}), 32'(2'b01));
                end
                if (done) begin
                    done_cnt++;
                    check("done follows last data_valid", 32'(p_dv), 32'(1));
                end
                if (p_done) check("ready one cycle after done", 32'(ready), 32'(1));
                if (!rd_n) rd_run++;
                else if (!p_rd) begin
                    check("rd_n low width", 32'(rd_run), 32'(3));
                    rd_run = 0;
                end
                if (!cs_n) begin
                    cs_run++;
                    cs_low_cnt++;
                end else if (!p_cs) begin
                    check("cs_n low span (4 reads + 3 gaps)", 32'(cs_run), 32'(15));
                    cs_run = 0;
                end
                if (!convst_n && p_conv) conv_cnt++;
                p_rd = rd_n; p_cs = cs_n; p_dv = data_valid; p_done = done; p_conv = convst_n;
            end
        end
    end

    // Monitor for the NCH=1 build.
    int   dv_cnt1 = 0, done_cnt1 = 0, rd_run1 = 0, cs_run1 = 0;
    logic p_rd1 = 1'b1, p_cs1 = 1'b1, p_dv1 = 1'b0;
    initial begin : monitor1
        sample_t s;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_run1 = 0; cs_run1 = 0; p_rd1 = 1'b1; p_cs1 = 1'b1; p_dv1 = 1'b0;
            end else begin
                if (data_valid1) begin
                    dv_cnt1++;
                    check("nch1 scoreboard holds entry", 32'(exp_q1.size() > 0), 32'(1));
                    if (exp_q1.size() > 0) begin
                        s = exp_q1.pop_front();
                        check("nch1 sample {ch,data}", 32'({ch_out1, data_out1}), 32'(s));
                    end
                end
                if (done1) begin
                    done_cnt1++;
                    check("nch1 done follows data_valid", 32'(p_dv1), 32'(1));
                end
                if (!rd_n1) rd_run1++;
                else if (!p_rd1) begin
                    check("nch1 rd_n low width", 32'(rd_run1), 32'(2));
                    rd_run1 = 0;
                end
                if (!cs_n1) cs_run1++;
                else if (!p_cs1) begin
                    check("nch1 cs_n low span (no gap)", 32'(cs_run1), 32'(2));
                    cs_run1 = 0;
                end
                p_rd1 = rd_n1; p_cs1 = cs_n1; p_dv1 = data_valid1;
            end
        end
    end

    localparam logic [21:0] RST_VEC = {1'b1, 1'b1, 1'b1, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_frame();
        for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 12'h100 + 12'(k)});
    endtask

    // Called right after the start edge; returns once convst_n is high again.
    task automatic measure_convst(input string name);
        int w = 0;
        while (!convst_n && w < 50) begin
            w++;
            @(negedge clk);
        end
        check(name, 32'(w), 32'(2));
    endtask

    task automatic busy_pulse();
        tick(3);
        busy = 1'b1;
        tick(10);
        busy = 1'b0;
    endtask

    task automatic run_nominal(input string tag, input bit extra_start);
        int dv0, dn0, cv0, t;
        bit sent;
        dv0 = dv_cnt; dn0 = done_cnt; cv0 = conv_cnt;
        t = 0; sent = 1'b0;
        push_frame();
        pulse_start();
        check({tag, " ready falls after start"}, 32'(ready), 32'(0));
        check({tag, " err cleared by start"}, 32'(err), 32'(0));
        measure_convst({tag, " convst_n low width"});
        busy_pulse();
        while (!(done || err) && t < 300) begin
            if (extra_start && !sent && !rd_n) begin
                start = 1'b1;
                sent  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check({tag, " frame completes in bound"}, 32'(t < 300), 32'(1));
        tick(20);
        check({tag, " data_valid count"}, 32'(dv_cnt - dv0), 32'(4));
        check({tag, " done count"}, 32'(done_cnt - dn0), 32'(1));
        check({tag, " single convst per frame"}, 32'(conv_cnt - cv0), 32'(1));
        check({tag, " err after frame"}, 32'(err), 32'(0));
        check({tag, " ready after frame"}, 32'(ready), 32'(1));
        check({tag, " scoreboard drained"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t, dv0, dn0, cs0;
        reset = 1'b1; start = 1'b0; busy = 1'b0; start1 = 1'b0; busy1 = 1'b0;
        tick(3);
        check("reset outputs", 32'({convst_n, cs_n, rd_n, data_out, ch_out, data_valid, done, ready, err}), 32'(RST_VEC));
        check("nch1 reset outputs", 32'({convst_n1, cs_n1, rd_n1, data_out1, ch_out1, data_valid1, done1, ready1, err1}), 32'(RST_VEC));
        reset = 1'b0;
        tick(3);

        run_nominal("nominal", 1'b0);

        // BUSY never rises: 64 clocks in WAIT_BH, then timeout.
        dv0 = dv_cnt; dn0 = done_cnt; cs0 = cs_low_cnt;
        pulse_start();
        measure_convst("no-busy convst_n low width");
        t = 0;
        while (!err && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("no-busy clocks in WAIT_BH", 32'(t), 32'(64));
        tick(2);
        check("no-busy err", 32'(err), 32'(1));
        check("no-busy ready", 32'(ready), 32'(1));
        check("no-busy cs_n never low", 32'(cs_low_cnt - cs0), 32'(0));
        check("no-busy no done/data_valid", 32'((done_cnt - dn0) + (dv_cnt - dv0)), 32'(0));

        // BUSY stuck high: timeout in WAIT_BL.
        pulse_start();
        check("stuck start clears err", 32'(err), 32'(0));
        measure_convst("stuck convst_n low width");
        tick(3);
        busy = 1'b1;
        t = 0;
        while (!err && t < 300) begin
            t++;
            @(negedge clk);
        end
        check("stuck err", 32'(err), 32'(1));
        check("stuck cs_n never low", 32'(cs_low_cnt - cs0), 32'(0));
        check("stuck no done/data_valid", 32'((done_cnt - dn0) + (dv_cnt - dv0)), 32'(0));
        busy = 1'b0;
        tick(5);
        run_nominal("after-stuck", 1'b0);

        run_nominal("start-during-read", 1'b1);

        // Reset while channel 2 is being read.
        dv0 = dv_cnt;
        push_frame();
        pulse_start();
        measure_convst("abort convst_n low width");
        busy_pulse();
        t = 0;
        while (!(dv_cnt - dv0 == 2 && !rd_n) && t < 300) begin
            t++;
            @(negedge clk);
        end
        check("abort reached channel-2 read", 32'(t < 300), 32'(1));
        reset = 1'b1;
        #1;
        check("abort outputs reset immediately", 32'({convst_n, cs_n, rd_n, data_out, ch_out, data_valid, done, ready, err}), 32'(RST_VEC));
        check("abort unread channels left", 32'(exp_q.size()), 32'(2));
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(3);
        dn0 = done_cnt;
        run_nominal("post-reset", 1'b0);

        // NCH=1, RD_CYCLES=2 build.
        dv0 = dv_cnt1; dn0 = done_cnt1;
        exp_q1.push_back({2'd0, 12'h100});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        t = 0;
        while (!convst_n1 && t < 50) begin
            t++;
            @(negedge clk);
        end
        check("nch1 convst_n low width", 32'(t), 32'(2));
        tick(3);
        busy1 = 1'b1;
        tick(10);
        busy1 = 1'b0;
        t = 0;
        while (!(done1 || err1) && t < 300) begin
            t++;
            @(negedge clk);
        end
        tick(5);
        check("nch1 data_valid count", 32'(dv_cnt1 - dv0), 32'(1));
        check("nch1 done count", 32'(done_cnt1 - dn0), 32'(1));
        check("nch1 err", 32'(err1), 32'(0));
        check("nch1 ready", 32'(ready1), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
